// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter sharing one registered bitwise logic unit (AND/OR/NOT/NAND) among N_REQ requesters.
// Optional build macro GATE_ARB_XOR_EN adds NOR (100) and XOR (101) opcodes.
module gate_op_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_REQ = 4
) (
  input  logic                       iClk,
  input  logic                       iRst,
  input  logic [N_REQ-1:0]           iReq,
  input  logic [3*N_REQ-1:0]         iOp,
  input  logic [WIDTH*N_REQ-1:0]     iA,
  input  logic [WIDTH*N_REQ-1:0]     iB,
  input  logic                       iReady,
  output logic [N_REQ-1:0]           oGnt,
  output logic                       oValid,
  output logic [WIDTH-1:0]           oResult,
  output logic [$clog2(N_REQ)-1:0]   oReqId,
  output logic                       oErr
);

  localparam int unsigned IDW = $clog2(N_REQ);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;

  logic [2:0]       op_arr [N_REQ];
  logic [WIDTH-1:0] a_arr  [N_REQ];
  logic [WIDTH-1:0] b_arr  [N_REQ];
  logic             pick_found;
  logic [IDW-1:0]   pick_idx;
  logic [IDW-1:0]   cand_idx;
  logic [WIDTH:0]   eval;

  // Returns {err, result}; undecoded opcodes yield a zero result with err set.
  function automatic logic [WIDTH:0] gate_eval(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      3'b000:  gate_eval = {1'b0, a & b};
      3'b001:  gate_eval = {1'b0, a | b};
      3'b010:  gate_eval = {1'b0, ~a};
      3'b011:  gate_eval = {1'b0, ~(a & b)};
`ifdef GATE_ARB_XOR_EN
      3'b100:  gate_eval = {1'b0, ~(a | b)};
      3'b101:  gate_eval = {1'b0, a ^ b};
`endif
      default: gate_eval = {1'b1, {WIDTH{1'b0}}};
    endcase
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      op_arr[i] = iOp[3*i +: 3];
      a_arr[i]  = iA[WIDTH*i +: WIDTH];
      b_arr[i]  = iB[WIDTH*i +: WIDTH];
    end
  end

  // First set request bit scanning from ptr upward with wrap.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand_idx = IDW'((32'(ptr_q) + k) % N_REQ);
      if (!pick_found && iReq[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  assign eval = gate_eval(op_q, a_q, b_q);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    gnt_d    = '0;
    valid_d  = valid_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          id_d            = pick_idx;
          op_d            = op_arr[pick_idx];
          a_d             = a_arr[pick_idx];
          b_d             = b_arr[pick_idx];
          gnt_d[pick_idx] = 1'b1;
          state_d         = EXEC;
        end
      end
      EXEC: begin
        err_d    = eval[WIDTH];
        result_d = eval[WIDTH-1:0];
        valid_d  = 1'b1;
        state_d  = HOLD;
      end
      HOLD: begin
        if (iReady) begin
          valid_d = 1'b0;
          ptr_d   = (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + IDW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      gnt_q    <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      gnt_q    <= gnt_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign oGnt    = gnt_q;
  assign oValid  = valid_q;
  assign oResult = result_q;
  assign oReqId  = id_q;
  assign oErr    = err_q;

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Directed bench for gate_op_arbiter: opcode vector table plus reset, round-robin,
// backpressure and operand-change sequences. Honours GATE_ARB_XOR_EN for expectations.
module tb_gate_op_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  iReq;
  logic [11:0] iOp;
  logic [31:0] iA;
  logic [31:0] iB;
  logic        iReady;
  logic [3:0]  oGnt;
  logic        oValid;
  logic [7:0]  oResult;
  logic [1:0]  oReqId;
  logic        oErr;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  gate_op_arbiter #(.WIDTH(8), .N_REQ(4)) dut (
    .iClk(clk), .iRst(rst), .iReq(iReq), .iOp(iOp), .iA(iA), .iB(iB),
    .iReady(iReady), .oGnt(oGnt), .oValid(oValid), .oResult(oResult),
    .oReqId(oReqId), .oErr(oErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       err;
    logic [1:0] id;
  } vec_t;

  vec_t vt [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int s, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    iOp = 12'($urandom);
    iA  = $urandom;
    iB  = $urandom;
    iOp[3*s +: 3] = op;
    iA[8*s +: 8]  = a;
    iB[8*s +: 8]  = b;
  endtask

  task automatic wait_gnt(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (oGnt != 4'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("gnt_timeout", 32'(oGnt), 32'hF);
  endtask

  int   rr_exp [8] = '{0, 1, 2, 3, 0, 1, 3, 1};
  logic ok;

  initial begin
    vt[0] = '{4'b0001, 3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0, 2'd0};
    vt[1] = '{4'b0010, 3'b001, 8'hAA, 8'h0F, 8'hAF, 1'b0, 2'd1};
    vt[2] = '{4'b0100, 3'b010, 8'hAA, 8'h0F, 8'h55, 1'b0, 2'd2};
    vt[3] = '{4'b1000, 3'b011, 8'hAA, 8'h0F, 8'hF5, 1'b0, 2'd3};
`ifdef GATE_ARB_XOR_EN
    vt[4] = '{4'b0001, 3'b101, 8'hAA, 8'h0F, 8'hA5, 1'b0, 2'd0};
    vt[6] = '{4'b0100, 3'b100, 8'hAA, 8'h0F, 8'h50, 1'b0, 2'd2};
`else
    vt[4] = '{4'b0001, 3'b101, 8'hAA, 8'h0F, 8'h00, 1'b1, 2'd0};
    vt[6] = '{4'b0100, 3'b100, 8'hAA, 8'h0F, 8'h00, 1'b1, 2'd2};
`endif
    vt[5] = '{4'b0010, 3'b111, 8'hAA, 8'h0F, 8'h00, 1'b1, 2'd1};
    vt[7] = '{4'b1000, 3'b110, 8'hAA, 8'h0F, 8'h00, 1'b1, 2'd3};
    vt[8] = '{4'b0001, 3'b000, 8'hFF, 8'hFF, 8'hFF, 1'b0, 2'd0};
    vt[9] = '{4'b0010, 3'b011, 8'h00, 8'h00, 8'hFF, 1'b0, 2'd1};

    // Reset held with random inputs: everything stays zero
    rst    = 1'b1;
    iReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      iReq   = 4'($urandom);
      iOp    = 12'($urandom);
      iA     = $urandom;
      iB     = $urandom;
      iReady = 1'($urandom);
      step();
      check("rst_gnt", 32'(oGnt), 32'h0);
      check("rst_valid", 32'(oValid), 32'h0);
      check("rst_result", 32'(oResult), 32'h0);
      check("rst_id", 32'(oReqId), 32'h0);
      check("rst_err", 32'(oErr), 32'h0);
    end
    iReq   = 4'b0;
    iReady = 1'b1;
    rst    = 1'b0;

    // Opcode table, one single-requester transaction each
    for (int i = 0; i < 10; i++) begin
      load(int'(vt[i].id), vt[i].op, vt[i].a, vt[i].b);
      iReq = vt[i].req;
      wait_gnt(ok);
      if (ok) begin
        check("vec_gnt", 32'(oGnt), 32'(4'b0001 << vt[i].id));
        check("vec_valid_early", 32'(oValid), 32'h0);
        iReq = 4'b0;
        step();
        check("vec_gnt_pulse", 32'(oGnt), 32'h0);
        check("vec_valid", 32'(oValid), 32'h1);
        check("vec_result", 32'(oResult), 32'(vt[i].res));
        check("vec_err", 32'(oErr), 32'(vt[i].err));
        check("vec_id", 32'(oReqId), 32'(vt[i].id));
        step();
        check("vec_accept", 32'(oValid), 32'h0);
      end
      iReq = 4'b0;
    end

    // Round-robin from a freshly reset pointer
    rst = 1'b1;
    step();
    rst = 1'b0;
    load(0, 3'b000, 8'h00, 8'h00);
    iReq = 4'b1111;
    for (int j = 0; j < 8; j++) begin
      wait_gnt(ok);
      check("rr_gnt", 32'(oGnt), 32'(4'b0001 << rr_exp[j]));
      if (j == 5) iReq = 4'b1010;
    end
    iReq = 4'b0;
    step();
    step();
    step();

    // Backpressure: result held, no new grant while HOLD waits
    iReady = 1'b0;
    load(2, 3'b000, 8'hFF, 8'h0F);
    iReq = 4'b0100;
    wait_gnt(ok);
    check("bp_gnt", 32'(oGnt), 32'h4);
    iReq = 4'b0001;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", 32'(oValid), 32'h1);
      check("bp_result", 32'(oResult), 32'h0F);
      check("bp_id", 32'(oReqId), 32'h2);
      check("bp_no_gnt", 32'(oGnt), 32'h0);
    end
    iReady = 1'b1;
    step();
    check("bp_accept", 32'(oValid), 32'h0);
    check("bp_idle_gnt", 32'(oGnt), 32'h0);
    step();
    check("bp_next_gnt", 32'(oGnt), 32'h1);
    iReq = 4'b0;
    step();
    step();

    // Operand change after grant must not affect the latched result
    load(2, 3'b001, 8'h12, 8'h40);
    iReq = 4'b0100;
    wait_gnt(ok);
    check("chg_gnt", 32'(oGnt), 32'h4);
    iReq = 4'b0;
    iA[23:16] = 8'hFF;
    step();
    check("chg_result", 32'(oResult), 32'h52);
    check("chg_id", 32'(oReqId), 32'h2);
    step();

    // Reset asserted in HOLD aborts immediately
    iReady = 1'b0;
    load(1, 3'b000, 8'hFF, 8'hFF);
    iReq = 4'b0010;
    wait_gnt(ok);
    iReq = 4'b0;
    step();
    check("hold_valid", 32'(oValid), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", 32'(oValid), 32'h0);
    check("midrst_result", 32'(oResult), 32'h0);
    check("midrst_id", 32'(oReqId), 32'h0);
    step();
    rst    = 1'b0;
    iReady = 1'b1;
    load(3, 3'b010, 8'h0F, 8'h00);
    iReq = 4'b1000;
    step();
    check("postrst_gnt", 32'(oGnt), 32'h8);
    iReq = 4'b0;
    step();
    check("postrst_result", 32'(oResult), 32'hF0);
    check("postrst_id", 32'(oReqId), 32'h3);
    step();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", pass_cnt, chk_cnt);
    $fatal(1);
  end

endmodule
